// File: rtl/reg_wb_pkg.sv
// Shared widths and the mul/div result entry type for the ID-stage write-port arbiter.
package reg_wb_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding mul/div results until the register file write port is free.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    wb_entry_t   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= din;
    end

    assign head  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

endmodule

// File: rtl/reg_wb_arbiter.sv
// Register-file write-port arbiter (writeback first, then buffered mul/div results) and RAW/WAW scoreboard.
// Optional same-cycle result bypass when the FIFO is empty: define REG_WB_FIFO_BYPASS_EN.
module reg_wb_arbiter
    import reg_wb_pkg::wb_entry_t;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_waddr,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_rd,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0] md_wd,
    output logic              md_ready,
    input  logic [ADDR_W-1:0] id_addr1,
    input  logic [ADDR_W-1:0] id_addr2,
    input  logic              id_use1,
    input  logic              id_use2,
    input  logic              id_we,
    input  logic [ADDR_W-1:0] id_rd,
    output logic              stall,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wd
);

    localparam int NREG = 1 << ADDR_W;

    logic            pipe_slot;
    logic            pop;
    logic            byp;
    logic            push;
    logic            full;
    logic            empty;
    logic            hazard;
    wb_entry_t       head;
    wb_entry_t       din;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    assign pipe_slot = pipe_we && (pipe_waddr != '0);

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = pipe_waddr;
        rf_wd    = pipe_wd;
        pop      = 1'b0;
        byp      = 1'b0;
        if (rst) begin
            if (pipe_slot) begin
                rf_we = 1'b1;
            end else if (!empty) begin
                rf_we    = 1'b1;
                rf_waddr = head.rd;
                rf_wd    = head.data;
                pop      = 1'b1;
            end
`ifdef REG_WB_FIFO_BYPASS_EN
            else if (md_valid && (md_rd != '0)) begin
                rf_we    = 1'b1;
                rf_waddr = md_rd;
                rf_wd    = md_wd;
                byp      = 1'b1;
            end
`endif
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO may still accept.
    assign md_ready = rst && (!full || pop);
    assign push     = md_valid && md_ready && (md_rd != '0) && !byp;
    assign din      = '{rd: md_rd, data: md_wd};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Clears happen at the committing edge; a same-cycle issue to that register wins.
    always_comb begin
        busy_nxt = busy;
        if (pop) busy_nxt[head.rd] = 1'b0;
        if (byp) busy_nxt[md_rd]   = 1'b0;
        if (md_issue && (md_issue_rd != '0)) busy_nxt[md_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) busy <= '0;
        else      busy <= busy_nxt;
    end

    assign hazard = (id_use1 && busy[id_addr1]) ||
                    (id_use2 && busy[id_addr2]) ||
                    (id_we   && busy[id_rd]);
    assign stall  = !rst || hazard || full;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized self-checking bench for reg_wb_arbiter against a queue-based reference model.
module tb_reg_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wd;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_wd;
    logic        md_ready;
    logic [4:0]  id_addr1, id_addr2, id_rd;
    logic        id_use1, id_use2, id_we;
    logic        stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wd;

    int npass  = 0;
    int ntotal = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    bit   busy_m[32];

    reg_wb_arbiter #(.FIFO_DEPTH(DEPTH), .ADDR_W(5), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_we     (pipe_we),
        .pipe_waddr  (pipe_waddr),
        .pipe_wd     (pipe_wd),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .md_valid    (md_valid),
        .md_rd       (md_rd),
        .md_wd       (md_wd),
        .md_ready    (md_ready),
        .id_addr1    (id_addr1),
        .id_addr2    (id_addr2),
        .id_use1     (id_use1),
        .id_use2     (id_use2),
        .id_we       (id_we),
        .id_rd       (id_rd),
        .stall       (stall),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wd       (rf_wd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else             npass++;
    endtask

    task automatic idle_inputs();
        pipe_we = 0; pipe_waddr = 0; pipe_wd = 0;
        md_issue = 0; md_issue_rd = 0;
        md_valid = 0; md_rd = 0; md_wd = 0;
        id_addr1 = 0; id_addr2 = 0; id_rd = 0;
        id_use1 = 0; id_use2 = 0; id_we = 0;
    endtask

    // Compare this cycle's outputs against the model, then advance model and clock together.
    task automatic step();
        bit   e_we, e_rdy, e_stall, popped, bypassed;
        logic [4:0]  e_addr;
        logic [31:0] e_wd;
        #1;
        e_we = 0; e_addr = 0; e_wd = 0; popped = 0; bypassed = 0;
        if (!rst) begin
            e_rdy = 0;
            e_stall = 1;
        end else begin
            if (pipe_we && pipe_waddr != 0) begin
                e_we = 1; e_addr = pipe_waddr; e_wd = pipe_wd;
            end else if (q.size() > 0) begin
                e_we = 1; e_addr = q[0].rd; e_wd = q[0].d; popped = 1;
            end
`ifdef REG_WB_FIFO_BYPASS_EN
            else if (md_valid && md_rd != 0) begin
                e_we = 1; e_addr = md_rd; e_wd = md_wd; bypassed = 1;
            end
`endif
            e_rdy = (q.size() < DEPTH) || popped;
            e_stall = (id_use1 && busy_m[id_addr1]) || (id_use2 && busy_m[id_addr2]) ||
                      (id_we && busy_m[id_rd]) || (q.size() == DEPTH);
        end
        check("rf_we", rf_we, e_we);
        if (e_we) begin
            check("rf_waddr", rf_waddr, e_addr);
            check("rf_wd", rf_wd, e_wd);
        end
        check("md_ready", md_ready, e_rdy);
        check("stall", stall, e_stall);

        if (!rst) begin
            q.delete();
            foreach (busy_m[i]) busy_m[i] = 0;
        end else begin
            if (popped) begin
                busy_m[q[0].rd] = 0;
                void'(q.pop_front());
            end
            if (bypassed) busy_m[md_rd] = 0;
            if (md_valid && e_rdy && md_rd != 0 && !bypassed) q.push_back('{md_rd, md_wd});
            if (md_issue && md_issue_rd != 0) busy_m[md_issue_rd] = 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        pipe_we     = ($urandom_range(0, 99) < 60);
        pipe_waddr  = 5'($urandom_range(0, 7));
        pipe_wd     = $urandom;
        md_issue    = ($urandom_range(0, 99) < 30);
        md_issue_rd = 5'($urandom_range(0, 7));
        md_valid    = ($urandom_range(0, 99) < 40);
        md_rd       = 5'($urandom_range(0, 7));
        md_wd       = $urandom;
        id_addr1    = 5'($urandom_range(0, 7));
        id_addr2    = 5'($urandom_range(0, 7));
        id_rd       = 5'($urandom_range(0, 7));
        id_use1     = 1'($urandom_range(0, 1));
        id_use2     = 1'($urandom_range(0, 1));
        id_we       = 1'($urandom_range(0, 1));
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        @(posedge clk);
        #1;

        // Reset held low, then released.
        step();
        step();
        rst = 1;
        step();
        check("rst_stall_released", stall, 1'b0);
        check("rst_ready_released", md_ready, 1'b1);

        // Scoreboard plus writeback priority over a waiting result.
        md_issue = 1; md_issue_rd = 10;
        step();
        md_issue = 0;
        id_use1 = 1; id_addr1 = 10;
        step();
        check("sb_stall_busy", stall, 1'b1);
        pipe_we = 1; pipe_waddr = 5; pipe_wd = 32'h12345678;
        md_valid = 1; md_rd = 10; md_wd = 32'hABCDEF12;
        step();
        md_valid = 0;
        step();
        pipe_we = 0;
        #1;
        check("drain_waddr", rf_waddr, 5'd10);
        check("drain_wd", rf_wd, 32'hABCDEF12);
        step();
        step();
        id_addr1 = 0;
        step();
        id_use1 = 0;

        // FIFO full under continuous writeback traffic.
        pipe_we = 1; pipe_waddr = 3; pipe_wd = 32'h33;
        md_valid = 1; md_rd = 6; md_wd = 32'h66;
        step();
        md_rd = 7; md_wd = 32'h77;
        step();
        md_rd = 8; md_wd = 32'h88;
        #1;
        check("full_ready", md_ready, 1'b0);
        check("full_stall", stall, 1'b1);
        step();
        md_valid = 0;
        pipe_we = 0;
        #1;
        check("full_pop_order", rf_waddr, 5'd6);
        step();
        step();

        // x0 handling: suppressed writeback drains, x0 result is dropped.
        pipe_we = 1; pipe_waddr = 4;
        md_valid = 1; md_rd = 9; md_wd = 32'h99;
        step();
        pipe_waddr = 0;
        md_rd = 0; md_wd = 32'hDEAD;
        step();
        pipe_we = 0; md_valid = 0;
        step();

        // Reset while the FIFO holds two entries.
        pipe_we = 1; pipe_waddr = 2;
        md_issue = 1; md_issue_rd = 11;
        md_valid = 1; md_rd = 11; md_wd = 32'hB1;
        step();
        md_issue = 0; md_rd = 12; md_wd = 32'hC1;
        step();
        idle_inputs();
        rst = 0;
        step();
        rst = 1;
        id_use1 = 1; id_addr1 = 11;
        step();
        check("post_rst_no_write", rf_we, 1'b0);
        step();
        idle_inputs();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 199) != 0);
            step();
        end
        rst = 1;
        idle_inputs();
        for (int i = 0; i < 4; i++) step();

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
